// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority encoder / arbiter.
package prio_pkg;

    localparam int unsigned DefaultN = 8;

    // Encoded index reported when no request is set; truncate to the index width at use.
    localparam logic [31:0] EmptyIdxAll = '1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_rr_search.sv
// Combinational rotated priority search: scans ptr-1, ptr-2, ... down to ptr (mod N).
module prio_rr_search
    import prio_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int unsigned      cand;
    logic [W-1:0]     cand_idx;

    always_comb begin
        idx      = EmptyIdxAll[W-1:0];
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand     = (32'(ptr) + N - k) % N;
            cand_idx = cand[W-1:0];
            if (!any && req[cand_idx]) begin
                idx = cand_idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority encoder with valid/ready handshake. Fixed priority by default;
// define PRIO_ENC_ARB_RR_EN for round-robin search with a pointer register.
module prio_enc_arb
    import prio_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [clog2(N)-1:0]   out_idx,
    output logic                  out_any,
    output logic [N-1:0]          out_onehot
);

    localparam int unsigned    W        = clog2(N);
    localparam logic [W-1:0]   EmptyIdx = EmptyIdxAll[W-1:0];

    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_idx_q, out_idx_d;
    logic           out_any_q, out_any_d;
    logic [N-1:0]   out_onehot_q, out_onehot_d;

    logic [W-1:0]   search_ptr;
    logic [W-1:0]   search_idx;
    logic           search_any;
    logic [N-1:0]   search_onehot;
    logic           accept;

    // A zero pointer gives the plain highest-index-first order.
`ifdef PRIO_ENC_ARB_RR_EN
    logic [W-1:0]   ptr_q, ptr_d;

    assign search_ptr = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (accept && search_any) begin
            ptr_d = search_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign search_ptr = '0;
`endif

    prio_rr_search #(
        .N (N),
        .W (W)
    ) u_search (
        .req (req),
        .ptr (search_ptr),
        .idx (search_idx),
        .any (search_any)
    );

    assign in_ready = en && rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        search_onehot = '0;
        if (search_any) begin
            search_onehot[search_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_any_d    = out_any_q;
        out_onehot_d = out_onehot_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_idx_d    = search_idx;
            out_any_d    = search_any;
            out_onehot_d = search_onehot;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_idx_q    <= EmptyIdx;
            out_any_q    <= 1'b0;
            out_onehot_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_any_q    <= out_any_d;
            out_onehot_q <= out_onehot_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_any    = out_any_q;
    assign out_onehot = out_onehot_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Self-checking bench for prio_enc_arb: directed scenarios then randomized traffic
// against a behavioural grant model. Define PRIO_ENC_ARB_RR_EN to exercise round-robin.
module tb_prio_enc_arb;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   req;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_idx;
    logic           out_any;
    logic [N-1:0]   out_onehot;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic           m_valid;
    logic           m_any;
    logic [W-1:0]   m_idx;
    logic [N-1:0]   m_onehot;
    int unsigned    m_ptr;

    prio_enc_arb #(
        .N (N)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .req        (req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_any    (out_any),
        .out_onehot (out_onehot)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int hi_bit(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    // Requests strictly below the pointer win first (highest of them); otherwise the
    // highest overall request wins. With pointer 0 this is plain fixed priority.
    function automatic int ref_grant(input logic [N-1:0] v, input int unsigned p);
        logic [N-1:0] low;
        int unsigned  mask;
        mask = (32'd1 << p) - 32'd1;
        low  = v & mask[N-1:0];
        if (low != '0) return hi_bit(low);
        return hi_bit(v);
    endfunction

    task automatic cycle();
        logic exp_ready;
        logic acc;
        int   g;
        #1;
        exp_ready = rst_n && en && (!m_valid || out_ready);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = in_valid && exp_ready;
        g   = ref_grant(req, m_ptr);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid  = 1'b0;
            m_any    = 1'b0;
            m_idx    = '1;
            m_onehot = '0;
            m_ptr    = 0;
        end else if (acc) begin
            m_valid  = 1'b1;
            m_any    = (g >= 0);
            m_idx    = (g >= 0) ? W'(g) : '1;
            m_onehot = (g >= 0) ? (N'(1) << g) : '0;
`ifdef PRIO_ENC_ARB_RR_EN
            if (g >= 0) m_ptr = g;
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_idx", 32'(out_idx), 32'(m_idx));
        check("out_any", 32'(out_any), 32'(m_any));
        check("out_onehot", 32'(out_onehot), 32'(m_onehot));
    endtask

    task automatic drive(input logic r, input logic e, input logic iv, input logic orr,
                         input logic [N-1:0] rq);
        rst_n     = r;
        en        = e;
        in_valid  = iv;
        out_ready = orr;
        req       = rq;
        cycle();
    endtask

    initial begin
        logic [W-1:0] rr_seq [9];
        logic         r_rst;
        logic         r_en;
        logic         r_iv;
        logic         r_or;
        logic [N-1:0] r_req;

        m_valid  = 1'b0;
        m_any    = 1'b0;
        m_idx    = '1;
        m_onehot = '0;
        m_ptr    = 0;

        // Reset
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);

        // Basic encode
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'b0010_1100);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_idx", 32'(out_idx), 32'd5);
        check("basic_onehot", 32'(out_onehot), 32'h20);
        check("basic_any", 32'(out_any), 32'd1);

        // Empty request
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        check("empty_any", 32'(out_any), 32'd0);
        check("empty_idx", 32'(out_idx), 32'h7);
        check("empty_onehot", 32'(out_onehot), 32'h0);

        // Backpressure: hold for 3 cycles, then drain and accept together
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h12);
        check("bp_first_idx", 32'(out_idx), 32'd4);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h40);
            check("bp_held_idx", 32'(out_idx), 32'd4);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h40);
        check("bp_b2b_valid", 32'(out_valid), 32'd1);
        check("bp_b2b_idx", 32'(out_idx), 32'd6);

        // Drain, then en=0 blocks acceptance
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        check("en_off_valid", 32'(out_valid), 32'd0);

        // All requests held, nine accepts from a fresh reset
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
        rr_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
`ifdef PRIO_ENC_ARB_RR_EN
            check("rr_seq", 32'(out_idx), 32'(rr_seq[i]));
`endif
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0100);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0110);
`ifdef PRIO_ENC_ARB_RR_EN
        check("rr_after2", 32'(out_idx), 32'd1);
`endif
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'b1000_0100);
        check("rr_wrap", 32'(out_idx), 32'd7);

        // Reset mid-operation with a nonzero pointer
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("pre_rst_idx", 32'(out_idx), (m_ptr == 0) ? 32'd7 : 32'd5);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idx", 32'(out_idx), 32'h7);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        check("post_rst_idx", 32'(out_idx), 32'd7);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 39) != 0);
            r_en  = ($urandom_range(0, 7) != 0);
            r_iv  = ($urandom_range(0, 3) != 0);
            r_or  = ($urandom_range(0, 2) != 0);
            r_req = N'($urandom);
            if ($urandom_range(0, 7) == 0) r_req = '0;
            drive(r_rst, r_en, r_iv, r_or, r_req);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
